// File: rtl/reservation_station_issue.sv
// Reservation station with a registered issue stage, feeding one functional unit.
// Holds up to DEPTH renamed instructions, snoops three CDB ports for missing
// operands, and issues the lowest-index entry whose operands are both ready.
//
// Ports:
//   clk, rst_n (sync, active-low), flush
//   dispatch_*      : incoming renamed instruction, valid/ready handshake
//   cdb_valid/tag/data : three result broadcast ports, port k in slice k
//   issue_valid/issue_ready : handshake towards the functional unit
//   control_signals .. data_b : registered issue payload
//   occupancy       : valid entries in the station (output register excluded)
module reservation_station_issue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        dispatch_valid,
  output logic                        dispatch_ready,
  input  logic [10:0]                 dispatch_control_signals,
  input  logic [2:0]                  dispatch_branch_sel,
  input  logic                        dispatch_branch_prediction,
  input  logic [DATA_WIDTH-1:0]       dispatch_pc,
  input  logic [DATA_WIDTH-1:0]       dispatch_pc_value_at_prediction,
  input  logic [TAG_WIDTH-1:0]        dispatch_rd_phys_addr,
  input  logic                        dispatch_a_ready,
  input  logic                        dispatch_b_ready,
  input  logic [TAG_WIDTH-1:0]        dispatch_a_tag,
  input  logic [TAG_WIDTH-1:0]        dispatch_b_tag,
  input  logic [DATA_WIDTH-1:0]       dispatch_a_data,
  input  logic [DATA_WIDTH-1:0]       dispatch_b_data,
  input  logic [2:0]                  cdb_valid,
  input  logic [3*TAG_WIDTH-1:0]      cdb_tag,
  input  logic [3*DATA_WIDTH-1:0]     cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [10:0]                 control_signals,
  output logic [2:0]                  branch_sel,
  output logic                        branch_prediction,
  output logic [DATA_WIDTH-1:0]       pc,
  output logic [DATA_WIDTH-1:0]       pc_value_at_prediction,
  output logic [TAG_WIDTH-1:0]        rd_phys_addr,
  output logic [DATA_WIDTH-1:0]       data_a,
  output logic [DATA_WIDTH-1:0]       data_b,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  // Returns {hit, data}; the lowest matching port wins.
  function automatic logic [DATA_WIDTH:0] cdb_lookup(
    input logic [TAG_WIDTH-1:0]    tag,
    input logic [2:0]              vld,
    input logic [3*TAG_WIDTH-1:0]  tags,
    input logic [3*DATA_WIDTH-1:0] datas
  );
    logic [DATA_WIDTH:0] res;
    res = '0;
    for (int k = 2; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        res = {1'b1, datas[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    return res;
  endfunction

  // Entry storage
  logic [DEPTH-1:0]      vld_q, a_rdy_q, b_rdy_q, bpred_q;
  logic [TAG_WIDTH-1:0]  a_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  b_tag_q [DEPTH];
  logic [TAG_WIDTH-1:0]  rd_q    [DEPTH];
  logic [DATA_WIDTH-1:0] a_data_q[DEPTH];
  logic [DATA_WIDTH-1:0] b_data_q[DEPTH];
  logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] pcv_q   [DEPTH];
  logic [10:0]           ctrl_q  [DEPTH];
  logic [2:0]            bsel_q  [DEPTH];

  // Output register
  logic                  iv_q, bpred_o_q;
  logic [10:0]           ctrl_o_q;
  logic [2:0]            bsel_o_q;
  logic [DATA_WIDTH-1:0] pc_o_q, pcv_o_q, a_o_q, b_o_q;
  logic [TAG_WIDTH-1:0]  rd_o_q;

  logic [DATA_WIDTH:0]   a_wk [DEPTH];
  logic [DATA_WIDTH:0]   b_wk [DEPTH];
  logic [DATA_WIDTH:0]   da_lk, db_lk;
  logic [IdxW-1:0]       free_idx, sel_idx;
  logic [DEPTH-1:0]      elig;
  logic                  elig_any, disp_acc, out_free, sel_move;
  logic                  disp_a_rdy, disp_b_rdy;
  logic [DATA_WIDTH-1:0] disp_a_data, disp_b_data;
  logic [OccW-1:0]       occ;

  assign elig           = vld_q & a_rdy_q & b_rdy_q;
  assign elig_any       = |elig;
  assign dispatch_ready = ~&vld_q;
  assign disp_acc       = dispatch_valid && dispatch_ready && !flush;
  assign out_free       = !iv_q || issue_ready;
  assign sel_move       = out_free && elig_any && !flush;

  // Dispatch-cycle bypass from the CDB
  assign da_lk       = cdb_lookup(dispatch_a_tag, cdb_valid, cdb_tag, cdb_data);
  assign db_lk       = cdb_lookup(dispatch_b_tag, cdb_valid, cdb_tag, cdb_data);
  assign disp_a_rdy  = dispatch_a_ready || da_lk[DATA_WIDTH];
  assign disp_b_rdy  = dispatch_b_ready || db_lk[DATA_WIDTH];
  assign disp_a_data = dispatch_a_ready ? dispatch_a_data : da_lk[DATA_WIDTH-1:0];
  assign disp_b_data = dispatch_b_ready ? dispatch_b_data : db_lk[DATA_WIDTH-1:0];

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    occ      = '0;
    // Descending scan so the lowest index is the final assignment.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IdxW'(i);
      if (elig[i])   sel_idx  = IdxW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OccW'(vld_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      a_wk[i] = cdb_lookup(a_tag_q[i], cdb_valid, cdb_tag, cdb_data);
      b_wk[i] = cdb_lookup(b_tag_q[i], cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_acc && (free_idx == IdxW'(i))) begin
          vld_q[i]    <= 1'b1;
          a_rdy_q[i]  <= disp_a_rdy;
          b_rdy_q[i]  <= disp_b_rdy;
          a_tag_q[i]  <= dispatch_a_tag;
          b_tag_q[i]  <= dispatch_b_tag;
          a_data_q[i] <= disp_a_data;
          b_data_q[i] <= disp_b_data;
          rd_q[i]     <= dispatch_rd_phys_addr;
          pc_q[i]     <= dispatch_pc;
          pcv_q[i]    <= dispatch_pc_value_at_prediction;
          ctrl_q[i]   <= dispatch_control_signals;
          bsel_q[i]   <= dispatch_branch_sel;
          bpred_q[i]  <= dispatch_branch_prediction;
        end else begin
          if (sel_move && (sel_idx == IdxW'(i))) vld_q[i] <= 1'b0;
          if (vld_q[i] && !a_rdy_q[i] && a_wk[i][DATA_WIDTH]) begin
            a_rdy_q[i]  <= 1'b1;
            a_data_q[i] <= a_wk[i][DATA_WIDTH-1:0];
          end
          if (vld_q[i] && !b_rdy_q[i] && b_wk[i][DATA_WIDTH]) begin
            b_rdy_q[i]  <= 1'b1;
            b_data_q[i] <= b_wk[i][DATA_WIDTH-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iv_q      <= 1'b0;
      ctrl_o_q  <= '0;
      bsel_o_q  <= '0;
      bpred_o_q <= 1'b0;
      pc_o_q    <= '0;
      pcv_o_q   <= '0;
      rd_o_q    <= '0;
      a_o_q     <= '0;
      b_o_q     <= '0;
    end else if (flush) begin
      iv_q <= 1'b0;
    end else if (out_free) begin
      iv_q <= elig_any;
      if (elig_any) begin
        ctrl_o_q  <= ctrl_q[sel_idx];
        bsel_o_q  <= bsel_q[sel_idx];
        bpred_o_q <= bpred_q[sel_idx];
        pc_o_q    <= pc_q[sel_idx];
        pcv_o_q   <= pcv_q[sel_idx];
        rd_o_q    <= rd_q[sel_idx];
        a_o_q     <= a_data_q[sel_idx];
        b_o_q     <= b_data_q[sel_idx];
      end
    end
  end

  assign issue_valid            = iv_q;
  assign control_signals        = ctrl_o_q;
  assign branch_sel             = bsel_o_q;
  assign branch_prediction      = bpred_o_q;
  assign pc                     = pc_o_q;
  assign pc_value_at_prediction = pcv_o_q;
  assign rd_phys_addr           = rd_o_q;
  assign data_a                 = a_o_q;
  assign data_b                 = b_o_q;
  assign occupancy              = occ;

endmodule

// File: doc/reservation_station_issue.md
Name: reservation_station_issue

Overview:
- Single reservation station feeding one functional unit in the 3-way Tomasulo core; drives the RS side of rs_to_exec_if (issue_valid/issue_ready handshake plus operand and control payload).
- Accepts renamed instructions from dispatch and holds up to DEPTH entries.
- Snoops the 3 CDB ports to capture missing operands.
- Issues the lowest-index entry with both operands ready through a registered output stage.

Parameters:
- DATA_WIDTH, 32, operand/PC width
- DEPTH, 4, number of RS entries (power of 2, >=2)
- TAG_WIDTH, 6, physical register tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  misprediction flush; discards all entries and output register
- dispatch_valid  in  1  dispatch offers instruction
- dispatch_ready  out  1  free entry exists (!full)
- dispatch_control_signals  in  11  control word; [10:7]=func_sel
- dispatch_branch_sel  in  3  branch type
- dispatch_branch_prediction  in  1  predicted taken
- dispatch_pc  in  DATA_WIDTH  instruction PC/link value
- dispatch_pc_value_at_prediction  in  DATA_WIDTH  predicted target
- dispatch_rd_phys_addr  in  TAG_WIDTH  destination tag
- dispatch_a_ready, dispatch_b_ready  in  1 each  operand already valid
- dispatch_a_tag, dispatch_b_tag  in  TAG_WIDTH each  producer tag when not ready
- dispatch_a_data, dispatch_b_data  in  DATA_WIDTH each  operand value when ready
- cdb_valid  in  3  per-port broadcast valid
- cdb_tag  in  3*TAG_WIDTH  port k at [k*TAG_WIDTH +: TAG_WIDTH]
- cdb_data  in  3*DATA_WIDTH  port k at [k*DATA_WIDTH +: DATA_WIDTH]
- issue_valid  out  1  output register holds instruction
- issue_ready  in  1  FU accepts
- control_signals, branch_sel, branch_prediction, pc, pc_value_at_prediction, rd_phys_addr, data_a, data_b  out  (as dispatch)  registered issue payload
- occupancy  out  $clog2(DEPTH+1)  valid entries in station, excluding output register

Behaviour:
- Reset (rst_n=0 at posedge): all entry valid bits 0, issue_valid 0, all payload outputs 0, occupancy 0.
  - dispatch_ready is combinational from state and reads 1 after reset.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready && !flush.
  - Written to the lowest-index free entry, using the free mask at cycle start.
  - A slot freed in the same cycle is not reusable until the next cycle.
- Dispatch-cycle bypass: if an operand is not ready and any cdb_valid[k] port matches its tag in the dispatch cycle, the entry stores cdb_data[k] as ready.
- Wakeup:
  - Each cycle, every valid entry with an unready operand compares its tag to all 3 CDB ports.
  - On a match, the data is latched and the operand marked ready at that edge.
  - If several ports match, the lowest k wins.
  - Both operands may wake in the same cycle.
- Select:
  - An entry is eligible when valid, a_ready and b_ready, all from registered state (a CDB-woken entry becomes eligible the cycle after the broadcast).
  - Output register "free" = !issue_valid || issue_ready.
  - When free and any entry is eligible: the lowest-index eligible entry is copied into the output register and its valid bit cleared at that edge; issue_valid=1 next cycle.
  - When free and none is eligible: issue_valid goes 0.
- Latency: operands ready at dispatch → issue_valid exactly 1 cycle after the dispatch edge. CDB wakeup at cycle N → issue_valid at N+2.
- Hold: while issue_valid && !issue_ready, every payload output is stable and no entry moves.
- Back-to-back: with issue_ready=1 constantly, one instruction issues per cycle, no bubbles.
- Occupancy updates = +dispatch_accept −select_move, both in the same cycle. Full (occupancy==DEPTH) → dispatch_ready=0.
- Flush:
  - Highest priority: at the edge it clears all entries and issue_valid; dispatch and select in that cycle are discarded.
  - Payload registers may keep stale values but are gated by issue_valid=0.
- Reset mid-operation behaves as flush plus payload zeroing.

Test Plan:
- Reset, then dispatch 1 instr (a/b ready, data_a=5, data_b=7, rd=12) → issue_valid=1 next cycle with data_a=5, data_b=7, rd_phys_addr=12; occupancy 1→0.
- Dispatch with a unready tag=9; cdb_valid=3'b010, tag port1=9, data=0xDEADBEEF 3 cycles later → issue_valid asserted 2 cycles after broadcast, data_a=0xDEADBEEF.
- Dispatch with a unready tag=20 while CDB port0 broadcasts tag 20 data 0x42 in the same cycle → issues next cycle with data_a=0x42.
- Hold issue_ready=0, dispatch 5 ready instrs (DEPTH=4) → 1 in output register, 4 in entries, dispatch_ready=0, occupancy=4. Release issue_ready → 5 issues on consecutive cycles in index order, payload stable while stalled.
- Entries 0 (unready) and 1 (ready) valid → entry 1 issues first. Entry 0 issues after its wakeup.
- 3 entries occupied, issue_valid=1, assert flush 1 cycle → next cycle issue_valid=0, occupancy=0, dispatch_ready=1. A dispatch offered during flush is not issued.
